// File: rtl/uart_tx_sender.sv
// UART transmitter: baud-tick generator, one-entry holding buffer, start/data/[parity]/stop serialiser.
// Define UART_TX_PARITY_EN to compile in an even-parity bit after the data bits.
module uart_tx_sender #(
    parameter int unsigned DBIT     = 8,
    parameter int unsigned SB_TICK  = 16,
    parameter int unsigned DVSR     = 163,
    parameter int unsigned DVSR_BIT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr,
    input  logic [DBIT-1:0] w_data,
    output logic            ready,
    output logic            busy,
    output logic            tx_done_tick,
    output logic            tx
);

    // s must reach SB_TICK-1 for 1.5/2 stop bits, so it may need more than 4 bits
    localparam int unsigned S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int unsigned N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [DVSR_BIT-1:0]   b_q, b_d;
    logic [S_W-1:0]        s_q, s_d;
    logic [N_W-1:0]        n_q, n_d;
    logic [DBIT-1:0]       sh_q, sh_d;
    logic [DBIT-1:0]       buf_q, buf_d;
    logic                  bv_q, bv_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  s_tick;
`ifdef UART_TX_PARITY_EN
    logic                  par_q, par_d;
`endif

    assign s_tick = (b_q == DVSR_BIT'(DVSR - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            b_q     <= '0;
            s_q     <= '0;
            n_q     <= '0;
            sh_q    <= '0;
            buf_q   <= '0;
            bv_q    <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            s_q     <= s_d;
            n_q     <= n_d;
            sh_q    <= sh_d;
            buf_q   <= buf_d;
            bv_q    <= bv_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        s_d     = s_q;
        n_d     = n_q;
        sh_d    = sh_q;
        buf_d   = buf_q;
        bv_d    = bv_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif

        // baud counter runs only while a frame is on the line
        if (state_q == IDLE || s_tick) begin
            b_d = '0;
        end else begin
            b_d = b_q + DVSR_BIT'(1);
        end

        if (wr && !bv_q) begin
            buf_d = w_data;
            bv_d  = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bv_q) begin
                    sh_d    = buf_q;
                    bv_d    = 1'b0;
                    s_d     = '0;
                    n_d     = '0;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^buf_q;
`endif
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_W'(15)) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_W'(15)) begin
                        s_d  = '0;
                        sh_d = sh_q >> 1;
                        if (n_q == N_W'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + N_W'(1);
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_q == S_W'(15)) begin
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_W'(SB_TICK - 1)) begin
                        s_d     = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // line level follows the state being entered so tx is glitch-free
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    assign ready_d = ~bv_d;
    assign busy_d  = (state_d != IDLE) | bv_d;

    assign ready        = ready_q;
    assign busy         = busy_q;
    assign tx_done_tick = done_q;
    assign tx           = tx_q;

endmodule
